// File: rtl/signed_adder.sv
// signed_adder: registered sign-magnitude adder for the ANC datapath.
// Combinational add/compare on sign-magnitude operands feeding a single
// output register stage (1-cycle latency, 1 result per enabled clock).
// Optional build macro SIGNED_ADDER_SAT_EN: when defined, magnitude overflow
// saturates to the largest magnitude; when undefined, the magnitude wraps.
module signed_adder #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] AddOut,
    output logic             valid,
    output logic             ovf
);

    localparam int M = WIDTH - 1;

    logic         sa;
    logic         sb;
    logic [M-1:0] ma;
    logic [M-1:0] mb;
    logic [M:0]   sum;
    logic         res_sign;
    logic [M-1:0] res_mag;
    logic         res_ovf;

    assign sa  = a[WIDTH-1];
    assign sb  = b[WIDTH-1];
    assign ma  = a[M-1:0];
    assign mb  = b[M-1:0];
    assign sum = {1'b0, ma} + {1'b0, mb};

    // Next result: add magnitudes on equal signs, subtract smaller from larger otherwise.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        res_sign = 1'b0;
        res_mag  = '0;
        res_ovf  = 1'b0;
        if (sa == sb) begin
            res_sign = sa;
            if (sum[M]) begin
                res_ovf = 1'b1;
`ifdef SIGNED_ADDER_SAT_EN
                res_mag = '1;
`else
                res_mag = sum[M-1:0];
`endif
            end else begin
                res_mag = sum[M-1:0];
            end
        end else if (ma > mb) begin
            res_sign = sa;
            res_mag  = ma - mb;
        end else if (mb > ma) begin
            res_sign = sb;
            res_mag  = mb - ma;
        end
        // A zero magnitude is always emitted as +0 (covers -0 inputs and wrapped overflow).
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Output register: capture the result on enabled edges, hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AddOut <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else if (en) begin
            // NOTE: registered state uses non-blocking assignments so all flops update together.
            AddOut <= {res_sign, res_mag};
            ovf    <= res_ovf;
            valid  <= 1'b1;
        end else begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_adder.sv
// tb_signed_adder: directed-vector bench for signed_adder (WIDTH = 21).
// Expected values are hand-computed; the overflow vectors follow the
// SIGNED_ADDER_SAT_EN build macro.
module tb_signed_adder;

    localparam int WIDTH = 21;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] AddOut;
    logic             valid;
    logic             ovf;

    int tests_run;
    int tests_failed;

    signed_adder #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .a      (a),
        .b      (b),
        .AddOut (AddOut),
        .valid  (valid),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic ven);
        @(negedge clk);
        a  = va;
        b  = vb;
        en = ven;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] e_out,
                              input logic e_valid, input logic e_ovf);
        check({tag, ".out"},   32'(AddOut), 32'(e_out));
        check({tag, ".valid"}, 32'(valid),  32'(e_valid));
        check({tag, ".ovf"},   32'(ovf),    32'(e_ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        expect_out("reset", 21'h000000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Mixed signs: +100 + -1999 = -1899
        apply(21'h000064, 21'h1007CF, 1'b1);
        expect_out("mixed", 21'h10076B, 1'b1, 1'b0);

        // Cancellation and negative zero
        apply(21'h0001F4, 21'h1001F4, 1'b1);
        expect_out("cancel", 21'h000000, 1'b1, 1'b0);
        apply(21'h100000, 21'h100000, 1'b1);
        expect_out("negzero", 21'h000000, 1'b1, 1'b0);

        // Overflow, positive and negative operands
`ifdef SIGNED_ADDER_SAT_EN
        apply(21'h0FFFFF, 21'h000001, 1'b1);
        expect_out("ovf_pos", 21'h0FFFFF, 1'b1, 1'b1);
        apply(21'h1FFFFF, 21'h100001, 1'b1);
        expect_out("ovf_neg", 21'h1FFFFF, 1'b1, 1'b1);
`else
        apply(21'h0FFFFF, 21'h000001, 1'b1);
        expect_out("ovf_pos", 21'h000000, 1'b1, 1'b1);
        apply(21'h1FFFFF, 21'h100001, 1'b1);
        expect_out("ovf_neg", 21'h000000, 1'b1, 1'b1);
        apply(21'h1FFFFF, 21'h100003, 1'b1);
        expect_out("ovf_wrap", 21'h100002, 1'b1, 1'b1);
`endif
        // ovf holds while en is low
        apply(21'h000001, 21'h000001, 1'b0);
        check("ovf_hold", 32'(ovf), 32'd1);
        check("ovf_hold.valid", 32'(valid), 32'd0);

        // Enable hold
        apply(21'h000003, 21'h000004, 1'b1);
        expect_out("load7", 21'h000007, 1'b1, 1'b0);
        apply(21'h000010, 21'h100003, 1'b0);
        expect_out("hold", 21'h000007, 1'b0, 1'b0);
        apply(21'h000010, 21'h100003, 1'b1);
        expect_out("reen", 21'h00000D, 1'b1, 1'b0);

        // Back-to-back, en continuously high
        apply(21'h000005, 21'h000006, 1'b1);
        expect_out("b2b0", 21'h00000B, 1'b1, 1'b0);
        apply(21'h100005, 21'h100006, 1'b1);
        expect_out("b2b1", 21'h10000B, 1'b1, 1'b0);
        apply(21'h000005, 21'h100009, 1'b1);
        expect_out("b2b2", 21'h100004, 1'b1, 1'b0);
        apply(21'h100000, 21'h000007, 1'b1);
        expect_out("b2b3", 21'h000007, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with en=1 and nonzero inputs
        @(negedge clk);
        a  = 21'h000123;
        b  = 21'h000456;
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 21'h000000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_held", 21'h000000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_rst_idle", 21'h000000, 1'b0, 1'b0);
        apply(21'h000123, 21'h000456, 1'b1);
        expect_out("post_rst", 21'h000579, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/signed_adder.md
Name: signed_adder

Overview:
- Registered sign-magnitude adder for the ANC datapath.
- Operands and result use a sign bit at the MSB and an unsigned magnitude below it (default 21 bits: bit 20 = sign, 19:0 = magnitude).
- Sits between filter tap products and the accumulator/output stage.
- Produces one result per enabled clock with 1-cycle latency.

Parameters:
- WIDTH, 21, total word width including sign bit (magnitude = WIDTH-1 bits; minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  enable; when high, inputs are sampled and the result registered
- a  input  WIDTH  operand A, sign-magnitude (a[WIDTH-1]=1 means negative)
- b  input  WIDTH  operand B, sign-magnitude
- AddOut  output  WIDTH  registered sign-magnitude sum
- valid  output  1  high for the one cycle after an enabled sample
- ovf  output  1  magnitude overflow flag for the current AddOut

Interface rule (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, any time, asynchronous): AddOut=0, valid=0, ovf=0. This takes effect immediately and holds until the first enabled edge after release. An in-flight sample is discarded.
- Latency: on a rising clk edge with en=1, a and b are sampled. AddOut, ovf and valid=1 update at that same edge, so results are visible 1 cycle after inputs are presented. Throughput is 1 per cycle.
- en=0 at an edge: AddOut and ovf hold their previous values; valid=0.
- Magnitudes are M=WIDTH-1 bits. Let sa, sb be the signs and ma, mb the magnitudes.
- Same signs (sa==sb):
  - sum = ma+mb computed in M+1 bits; result sign = sa.
  - If sum > 2^M-1, ovf=1 and the overflow handling below applies.
  - Otherwise magnitude = sum and ovf=0.
- Different signs:
  - If ma>mb: magnitude = ma-mb, sign = sa.
  - If mb>ma: magnitude = mb-ma, sign = sb.
  - If ma==mb: result is +0.
  - ovf=0 in all three cases.
- Zero normalisation: negative-zero inputs are valid and treated as zero. Any zero-magnitude result is emitted with sign 0; the block never outputs -0.
- Overflow handling is selected by the optional feature below.
- Purely combinational add/compare in front of one output register stage. No internal state beyond the output registers.

Optional Feature:
- Macro: SIGNED_ADDER_SAT_EN.
- Defined: on overflow, magnitude saturates to 2^M-1 with the operand sign, and ovf=1.
- Undefined: on overflow, magnitude wraps to sum mod 2^M with the operand sign, and ovf=1. If the wrapped magnitude is 0, the sign is forced to 0 per the zero rule.
- The overflow flag behaves identically in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-stream with en=1 and nonzero inputs -> AddOut=21'h000000, valid=0, ovf=0 immediately. These values hold until the first enabled edge after release.
- Mixed signs: a=21'h000064 (+100), b=21'h1007CF (-1999), en=1 -> next cycle AddOut=21'h10076B (-1899), valid=1, ovf=0.
- Cancellation and negative zero:
  - a=+500 (21'h0001F4), b=-500 (21'h1001F4) -> AddOut=21'h000000.
  - a=21'h100000, b=21'h100000 (-0 + -0) -> AddOut=21'h000000.
- Overflow: a=21'h0FFFFF, b=21'h000001.
  - SAT_EN defined -> AddOut=21'h0FFFFF, ovf=1.
  - SAT_EN undefined -> AddOut=21'h000000, ovf=1.
  - Same with both operands negative and SAT_EN defined -> AddOut=21'h1FFFFF, ovf=1.
- Enable hold: load +3 + +4 (AddOut=21'h000007), then drop en and change inputs -> AddOut stays 21'h000007, valid=0. Re-assert en -> the new sum appears next cycle.
- Back-to-back: en=1 for 4 consecutive cycles with distinct operand pairs -> 4 consecutive correct results, each one cycle after its inputs, with valid continuously high.
